axi_lite_master_seq: RTL
========================

AXI_LITE_MASTER_SEQ -- requirements
Module: axi_lite_master_seq

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 8, significant AXI-Lite address bits driven; upper address bits are zero.
- TIMEOUT_CYC, 1024, watchdog limit in clock cycles, used only with AXIL_MST_TIMEOUT_EN.

REQ-002 Ports SHALL be (clock and reset first):
- axi_lite_aclk_in  in  1  sole clock.
- reset0_in  in  1  asynchronous, active-high reset.
- cmd_valid_in / cmd_ready_out  in/out  1  command handshake.
- cmd_write_in  in  1  1=write, 0=read.
- cmd_addr_in  in  32  byte address.
- cmd_wdata_in  in  32  write data.
- cmd_wstrb_in  in  4  write strobes.
- rsp_valid_out / rsp_ready_in  out/in  1  response handshake.
- rsp_write_out  out  1  echo of the command type.
- rsp_rdata_out  out  32  read data; 0 for writes.
- rsp_resp_out  out  2  BRESP or RRESP.
- m_axi_aw{addr(32),prot(3),valid}_out, m_axi_awready_in: AXI4-Lite master write-address channel.
- m_axi_w{data(32),strb(4),valid}_out, m_axi_wready_in: write-data channel.
- m_axi_b{resp(2)}_in, m_axi_bvalid_in, m_axi_bready_out: write-response channel.
- m_axi_ar{addr(32),prot(3),valid}_out, m_axi_arready_in: read-address channel.
- m_axi_r{data(32),resp(2)}_in, m_axi_rvalid_in, m_axi_rready_out: read-data channel.
- timeout_err_out  out  1  sticky watchdog flag (AXIL_MST_TIMEOUT_EN only).

Function
REQ-003 The block SHALL process one transaction at a time, using the FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
REQ-004 cmd_ready_out SHALL be 1 only in IDLE. A cmd_valid_in&cmd_ready_out handshake SHALL register the command and move to WR_REQ or RD_REQ on the next edge.
REQ-005 In WR_REQ, awvalid and wvalid SHALL assert together. Each SHALL deassert independently on its own ready. The FSM SHALL move to WR_RESP only once both handshakes have completed, including when both complete in the same cycle.
REQ-006 In WR_RESP, bready SHALL be 1. On bvalid the FSM SHALL capture bresp and go to RSP.
REQ-007 In RD_REQ, arvalid SHALL be 1 until arready, then the FSM SHALL go to RD_RESP. In RD_RESP, rready SHALL be 1; on rvalid the FSM SHALL capture rdata and rresp and go to RSP.
REQ-008 A valid signal SHALL never drop before its handshake. Address, data and strobe outputs SHALL be stable while their valid is high.
REQ-009 awaddr and araddr SHALL equal {zeros, cmd_addr[ADDR_W-1:0]}. prot SHALL be 3'b000.
REQ-010 In RSP, rsp_valid_out SHALL be 1 and hold its data until rsp_ready_in, then the FSM SHALL return to IDLE.
REQ-011 Minimum latency, with all AXI readys and valids immediately available, SHALL be 4 cycles from command handshake to rsp_valid_out.
REQ-012 Non-OKAY responses SHALL be passed through unchanged and SHALL NOT cause a retry.

Reset
REQ-013 While reset0_in is high, the FSM SHALL be IDLE and all valid/ready outputs, rsp_* and timeout_err_out SHALL be 0. Asserting reset mid-transaction SHALL abandon the transaction immediately.
REQ-014 After reset deasserts, cmd_ready_out SHALL rise in the first clock.

Configuration
REQ-015 With AXIL_MST_TIMEOUT_EN defined, a counter SHALL run in WR_REQ, WR_RESP, RD_REQ and RD_RESP, and clear on every state change.
- On reaching TIMEOUT_CYC it SHALL set timeout_err_out.
- The FSM SHALL NOT abort, because the AXI rules forbid it.
- timeout_err_out SHALL clear on the next accepted command.
REQ-016 Without AXIL_MST_TIMEOUT_EN, the counter SHALL be absent and timeout_err_out SHALL be tied to 0.

Structure
REQ-017 The FSM state enum and the AXI response codes (OKAY, EXOKAY, SLVERR, DECERR) SHALL live in the shared package axil_pkg.
REQ-018 The design SHALL be a single module with no sub-module; the watchdog stays inline.

Verification
REQ-019 Write 0x10 with 0xDEADBEEF and strb 0xF, using a zero-wait-state slave: exactly one AW and one W with those values; rsp_write=1, resp=00, response after 4 cycles.
REQ-020 Read 0x10 where the slave returns 0x12345678: ar addr=0x10, rsp_rdata=0x12345678, resp=00.
REQ-021 awready delayed 5 cycles while wready is immediate: wvalid drops after 1 cycle, awvalid held stable for 6 cycles, and exactly one B is accepted.
REQ-022 The slave returns rresp=10: rsp_resp=10, the next command is accepted normally, and no retry is issued.
REQ-023 rsp_ready_in held low for 10 cycles: response stable and cmd_ready_out=0 throughout.
REQ-024 With AXIL_MST_TIMEOUT_EN and TIMEOUT_CYC=16, bvalid withheld for 20 cycles: timeout_err_out=1 at cycle 16; a late B still completes; a reset pulse mid-WR_RESP returns the FSM to IDLE with all outputs 0.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: master sequencer FSM states and response codes.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } axil_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_master_seq.sv
// AXI4-Lite master running one command at a time: command in, one AXI transaction, one response out.
// Optional AXIL_MST_TIMEOUT_EN adds a sticky watchdog flag on stalled AXI phases (never aborts).
module axi_lite_master_seq
  import axil_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        axi_lite_aclk_in,
  input  logic        reset0_in,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic        cmd_write_in,
  input  logic [31:0] cmd_addr_in,
  input  logic [31:0] cmd_wdata_in,
  input  logic [3:0]  cmd_wstrb_in,
  output logic        rsp_valid_out,
  input  logic        rsp_ready_in,
  output logic        rsp_write_out,
  output logic [31:0] rsp_rdata_out,
  output logic [1:0]  rsp_resp_out,
  output logic [31:0] m_axi_awaddr_out,
  output logic [2:0]  m_axi_awprot_out,
  output logic        m_axi_awvalid_out,
  input  logic        m_axi_awready_in,
  output logic [31:0] m_axi_wdata_out,
  output logic [3:0]  m_axi_wstrb_out,
  output logic        m_axi_wvalid_out,
  input  logic        m_axi_wready_in,
  input  logic [1:0]  m_axi_bresp_in,
  input  logic        m_axi_bvalid_in,
  output logic        m_axi_bready_out,
  output logic [31:0] m_axi_araddr_out,
  output logic [2:0]  m_axi_arprot_out,
  output logic        m_axi_arvalid_out,
  input  logic        m_axi_arready_in,
  input  logic [31:0] m_axi_rdata_in,
  input  logic [1:0]  m_axi_rresp_in,
  input  logic        m_axi_rvalid_in,
  output logic        m_axi_rready_out,
  output logic        timeout_err_out
);

  axil_state_e       state_q, state_d;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              cmd_rdy_q;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic              cmd_hs;
  logic              unused_in;

  assign cmd_hs    = cmd_valid_in & cmd_rdy_q;
  assign unused_in = ^{cmd_addr_in, TIMEOUT_CYC[0]};

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          rdata_d = '0;
          resp_d  = AXI_RESP_OKAY;
          if (cmd_write_in) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; leave only when both are done.
        if (m_axi_awready_in) awvalid_d = 1'b0;
        if (m_axi_wready_in)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (m_axi_bvalid_in) begin
          resp_d  = m_axi_bresp_in;
          state_d = RSP;
        end
      end
      RD_REQ: begin
        if (m_axi_arready_in) begin
          arvalid_d = 1'b0;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_axi_rvalid_in) begin
          rdata_d = m_axi_rdata_in;
          resp_d  = m_axi_rresp_in;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // cmd_rdy_q is held low until the first clock after reset releases.
  always_ff @(posedge axi_lite_aclk_in or posedge reset0_in) begin
    if (reset0_in) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      cmd_rdy_q <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      cmd_rdy_q <= (state_d == IDLE);
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      if (cmd_hs) begin
        write_q <= cmd_write_in;
        addr_q  <= cmd_addr_in[ADDR_W-1:0];
        wdata_q <= cmd_wdata_in;
        wstrb_q <= cmd_wstrb_in;
      end
    end
  end

  assign cmd_ready_out     = cmd_rdy_q;
  assign rsp_valid_out     = (state_q == RSP);
  assign rsp_write_out     = write_q;
  assign rsp_rdata_out     = rdata_q;
  assign rsp_resp_out      = resp_q;
  assign m_axi_awaddr_out  = 32'(addr_q);
  assign m_axi_awprot_out  = AXI_PROT_DEFAULT;
  assign m_axi_awvalid_out = awvalid_q;
  assign m_axi_wdata_out   = wdata_q;
  assign m_axi_wstrb_out   = wstrb_q;
  assign m_axi_wvalid_out  = wvalid_q;
  assign m_axi_bready_out  = (state_q == WR_RESP);
  assign m_axi_araddr_out  = 32'(addr_q);
  assign m_axi_arprot_out  = AXI_PROT_DEFAULT;
  assign m_axi_arvalid_out = arvalid_q;
  assign m_axi_rready_out  = (state_q == RD_RESP);

`ifdef AXIL_MST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             wd_err_q, wd_err_d;
  logic             wd_busy;

  // Counts cycles spent in one AXI phase; saturates so the flag cannot re-trigger oddly.
  always_comb begin
    wd_busy  = (state_q == WR_REQ) || (state_q == WR_RESP) ||
               (state_q == RD_REQ) || (state_q == RD_RESP);
    wd_cnt_d = '0;
    if (wd_busy && (state_d == state_q)) begin
      wd_cnt_d = (wd_cnt_q == CNT_W'(TIMEOUT_CYC)) ? wd_cnt_q : wd_cnt_q + 1'b1;
    end
    wd_err_d = wd_err_q;
    if (cmd_hs) begin
      wd_err_d = 1'b0;
    end else if (wd_cnt_d == CNT_W'(TIMEOUT_CYC)) begin
      wd_err_d = 1'b1;
    end
  end

  always_ff @(posedge axi_lite_aclk_in or posedge reset0_in) begin
    if (reset0_in) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign timeout_err_out = wd_err_q;
`else
  assign timeout_err_out = 1'b0;
`endif

endmodule
